// File: rtl/din_sync_filter.sv
// Per-channel input synchroniser with optional debounce (DIN_FILTER_DEBOUNCE_EN),
// registered level, rise/fall pulses and a saturating rise-event counter.
module din_sync_filter #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [CNT_W-1:0] edge_cnt
);

  // Wide enough to hold the counter plus a full-bus popcount without overflow.
  localparam int unsigned SumW = CNT_W + $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s_last;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] rise_q, fall_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SumW-1:0]  pop, sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s_last = sync_q[SYNC_STAGES-1];

`ifdef DIN_FILTER_DEBOUNCE_EN
  localparam int unsigned DcntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DcntW-1:0] DcntLast = DcntW'(DEBOUNCE_CYCLES - 1);

  logic [DcntW-1:0] dcnt_q [WIDTH];
  logic [DcntW-1:0] dcnt_d [WIDTH];

  // dcnt counts consecutive cycles that s_last disagrees with dout.
  always_comb begin
    dout_d = dout_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      dcnt_d[i] = '0;
      if (s_last[i] == dout_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] == DcntLast) begin
        dout_d[i] = s_last[i];
      end else begin
        dcnt_d[i] = dcnt_q[i] + DcntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (rst) dcnt_q[i] <= '0;
      else     dcnt_q[i] <= dcnt_d[i];
    end
  end
`else
  assign dout_d = s_last;
`endif

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(WIDTH); i++) pop = pop + SumW'(rise_q[i]);
    sum = SumW'(cnt_q) + pop;
    if (clr) begin
      cnt_d = '0;
    end else if (sum > SumW'({CNT_W{1'b1}})) begin
      cnt_d = '1;
    end else begin
      cnt_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      cnt_q  <= '0;
    end else begin
      dout_q <= dout_d;
      rise_q <= dout_d & ~dout_q;
      fall_q <= ~dout_d & dout_q;
      cnt_q  <= cnt_d;
    end
  end

  assign dout     = dout_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign edge_cnt = cnt_q;

endmodule

// File: tb/tb_din_sync_filter.sv
// Randomised and directed bench for din_sync_filter against a sample-history model;
// a second instance with a 3-bit counter covers saturation.
module tb_din_sync_filter;

  localparam int unsigned W    = 4;
  localparam int unsigned Sync = 2;
  localparam int unsigned Deb  = 4;
`ifdef DIN_FILTER_DEBOUNCE_EN
  localparam int unsigned DEff = Deb;
`else
  localparam int unsigned DEff = 1;
`endif
  localparam int unsigned Lat  = Sync + DEff;
  localparam int unsigned HLen = Sync + DEff;

  logic         clk, rst, clr;
  logic [W-1:0] din;
  logic [W-1:0] dout, rise, fall;
  logic [7:0]   cnt8;
  logic [W-1:0] dout_s, rise_s, fall_s;
  logic [2:0]   cnt3;

  din_sync_filter #(.WIDTH(W), .SYNC_STAGES(Sync), .DEBOUNCE_CYCLES(Deb), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .din(din), .clr(clr),
    .dout(dout), .rise(rise), .fall(fall), .edge_cnt(cnt8)
  );

  din_sync_filter #(.WIDTH(W), .SYNC_STAGES(Sync), .DEBOUNCE_CYCLES(Deb), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .din(din), .clr(clr),
    .dout(dout_s), .rise(rise_s), .fall(fall_s), .edge_cnt(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: hist[j] is din as captured j edges ago; a level flips once the last
  // DEff synchronised samples all disagree with it.
  logic [W-1:0] hist [0:HLen];
  logic [W-1:0] m_dout, m_rise, m_fall, nd;
  int           m_cnt8, m_cnt3, pc;
  bit           agree;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_dout = '0; m_rise = '0; m_fall = '0; m_cnt8 = 0; m_cnt3 = 0;
        for (int j = 0; j <= int'(HLen); j++) hist[j] = '0;
      end else begin
        pc = $countones(m_rise);
        m_cnt8 = clr ? 0 : ((m_cnt8 + pc > 255) ? 255 : m_cnt8 + pc);
        m_cnt3 = clr ? 0 : ((m_cnt3 + pc > 7) ? 7 : m_cnt3 + pc);
        nd = m_dout;
        for (int i = 0; i < int'(W); i++) begin
          agree = 1'b1;
          for (int j = int'(Sync); j < int'(Sync + DEff); j++)
            if (hist[j][i] == m_dout[i]) agree = 1'b0;
          if (agree) nd[i] = ~m_dout[i];
        end
        m_rise = nd & ~m_dout;
        m_fall = ~nd & m_dout;
        m_dout = nd;
        for (int j = int'(HLen); j >= 2; j--) hist[j] = hist[j-1];
        hist[1] = din;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("dout", 32'(dout), 32'(m_dout));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        chk("edge_cnt", 32'(cnt8), 32'(m_cnt8));
        chk("edge_cnt_sat", 32'(cnt3), 32'(m_cnt3));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, expected finish by 2000000");
    $fatal(1);
  end

  int r_at, f_at, nrise, exp_cnt, hold;
  logic [W-1:0] v, nv;

  initial begin
    rst = 1'b1; clr = 1'b0; din = '0;
    repeat (2) step();
    chk_en = 1'b1;
    chk("reset_dout", 32'(dout), 0);
    chk("reset_cnt", 32'(cnt8), 0);
    rst = 1'b0;

    // Latency of a single-channel rise
    din = 4'b0001;
    repeat (Lat - 1) step();
    chk("lat_before", 32'(dout), 0);
    step();
    chk("lat_dout", 32'(dout), 1);
    chk("lat_rise", 32'(rise), 1);
    step();
    chk("lat_rise_gone", 32'(rise), 0);
    chk("lat_cnt", 32'(cnt8), 1);

    // Short glitch on channel 1, then a 4-cycle pulse
    nrise = 0;
    for (int k = 0; k < int'(3 + Lat + 6); k++) begin
      din[1] = (k < 3);
      step();
      if (rise[1]) nrise++;
    end
    chk("glitch_rises", 32'(nrise), (3 >= DEff) ? 1 : 0);
    r_at = -100; f_at = 0;
    for (int k = 0; k < int'(4 + Lat + 8); k++) begin
      din[1] = (k < 4);
      step();
      if (rise[1]) r_at = k;
      if (fall[1]) f_at = k;
    end
    chk("pulse_gap", 32'(f_at - r_at), 4);

    // All channels together
    din = '0; clr = 1'b1;
    repeat (Lat + 2) step();
    clr = 1'b0;
    din = 4'b1111;
    repeat (Lat) step();
    chk("multi_rise", 32'(rise), 15);
    step();
    chk("multi_cnt", 32'(cnt8), 4);
    din = 4'b0000;
    repeat (Lat) step();
    chk("multi_fall", 32'(fall), 15);
    step();
    chk("multi_cnt_hold", 32'(cnt8), 4);

    // Counting sweep
    rst = 1'b1; step(); rst = 1'b0;
    v = '0; exp_cnt = 0;
    for (int s = 0; s < 20; s++) begin
      nv = v + 4'd1;
      exp_cnt += $countones(nv & ~v);
      v = nv;
      din = v;
      repeat (8) step();
    end
    repeat (Lat) step();
    chk("sweep_cnt", 32'(cnt8), 32'(exp_cnt));
    chk("sweep_dout", 32'(dout), 32'(v));

    // Saturation of the 3-bit counter, then clear racing a rise
    rst = 1'b1; step(); rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      din = 4'b1111; repeat (Lat + 2) step();
      din = 4'b0000; repeat (Lat + 2) step();
    end
    chk("sat_cnt3", 32'(cnt3), 7);
    chk("sat_cnt8", 32'(cnt8), 12);
    din = 4'b0001;
    repeat (Lat) step();
    chk("clr_rise", 32'(rise), 1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_cnt3", 32'(cnt3), 0);
    chk("clr_cnt8", 32'(cnt8), 0);

    // Reset in the middle of a pending change
    din = 4'b0000;
    repeat (Lat + 2) step();
    din = 4'b0100;
    repeat (3) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_dout", 32'(dout), 0);
    chk("midrst_rise", 32'(rise), 0);
    chk("midrst_fall", 32'(fall), 0);
    repeat (Lat - 1) step();
    chk("relrst_early", 32'(rise), 0);
    step();
    chk("relrst_rise", 32'(rise), 4);

    // Random traffic with occasional clear and reset
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        din  = 4'($urandom);
        hold = int'($urandom_range(1, 9));
      end
      hold--;
      clr = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; clr = 1'b0;
    repeat (Lat + 2) step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
